step_profile_pulse_gen: RTL
===========================

STEP_PROFILE_PULSE_GEN -- requirements
Module: step_profile_pulse_gen

Interface
REQ-001 Parameter ACC_W, default 16: phase-accumulator width; pulse frequency = f_tick*freq/2^ACC_W.
REQ-002 Parameter DIN_W, default 32: FIFO word width; must be at least ACC_W+1.
REQ-003 Parameter TICK_DIV, default 25: sysclk cycles per tick (6.25 MHz/25 = 250 kHz); must be at least 2.
REQ-004 Parameter SEG_TICKS, default 250: ticks each FIFO word is applied.
REQ-005 Parameter POS_W, default 32: position counter width.
REQ-006 sysclk  in  1  the single clock.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 enable  in  1  run request; low forces IDLE.
REQ-009 din  in  DIN_W  profile word: bit DIN_W-1 = direction, bits ACC_W-1:0 = freq word, other bits ignored.
REQ-010 empty  in  1  FIFO empty.
REQ-011 vld  in  1  FIFO read-data valid; arrives one or more cycles after read.
REQ-012 clr_underrun  in  1  clears the underrun flag.
REQ-013 read  out  1  FIFO read strobe, one sysclk wide.
REQ-014 pulse  out  1  step output, registered accumulator MSB.
REQ-015 dir  out  1  registered direction of the active word.
REQ-016 tick  out  1  one-sysclk strobe every TICK_DIV cycles.
REQ-017 position  out  POS_W  signed step count.
REQ-018 busy  out  1  high whenever the state is not IDLE.
REQ-019 underrun  out  1  sticky flag: FIFO was empty at a segment boundary.

Function
REQ-020 Tick divider SHALL be free-running: counts 0..TICK_DIV-1, asserts tick when the count equals TICK_DIV-1, and runs in all states. No derived clocks; everything is clocked by sysclk and gated by tick.
REQ-021 FSM SHALL have four states: IDLE, FETCH, WAIT_VLD, RUN.
- IDLE->FETCH when enable=1 and empty=0.
- FETCH: read=1 for exactly one cycle, then WAIT_VLD.
- WAIT_VLD->RUN on vld: load freq and dir, set seg_cnt=SEG_TICKS-1.
REQ-022 Accumulator update: on each tick in FETCH, WAIT_VLD or RUN, acc <= acc+freq modulo 2^ACC_W; pulse <= new acc[ACC_W-1] in the same cycle.
REQ-023 Segment counting: in RUN, each tick decrements seg_cnt.
- When seg_cnt=0 and empty=0: go to FETCH. The old freq keeps accumulating until vld, so there is no tick gap.
- When seg_cnt=0 and empty=1: underrun<=1, go to IDLE.
REQ-024 Position counting: on a tick where acc[ACC_W-1] goes 0->1, position += 1 if dir=0, else -1. Wraps modulo 2^POS_W.
REQ-025 Entering IDLE for any reason SHALL clear acc, freq and pulse to 0 on the next cycle. position and dir are held.
REQ-026 enable=0 in any state SHALL force IDLE on the next sysclk.
- A vld arriving after this is ignored.
- A read already issued is not retracted.
REQ-027 If clr_underrun and an underrun set occur in the same cycle, set SHALL win.
REQ-028 freq=0 SHALL hold acc and produce no pulses, with segment timing unchanged.
REQ-029 read SHALL never be asserted while empty=1.

Reset
REQ-030 Asynchronous reset SHALL set state=IDLE, and SHALL set acc, freq, seg_cnt and the divider count to 0.
REQ-031 Asynchronous reset SHALL drive read, pulse, dir, tick, position, busy and underrun to 0.
REQ-032 Reset mid-RUN SHALL abort immediately with no further read; operation restarts from IDLE after release.

Structure
REQ-033 Package step_profile_pkg SHALL hold the FSM state enumeration and the default parameter constants.
REQ-034 One sub-module, tick_divider (parameter TICK_DIV, outputs tick), SHALL implement REQ-020.

Verification
Bench parameters for all scenarios: ACC_W=16, TICK_DIV=4, SEG_TICKS=8.
REQ-035 Reset asserted with random inputs -> all outputs 0; after release, tick every 4th sysclk.
REQ-036 One word 0x0000_4000 (dir=0), then empty -> 8 ticks of pulse with period 4 ticks, position=2, underrun=1, busy=0, pulse=0.
REQ-037 One word 0x8000_8000 (dir=1) -> position=-4 after the segment, dir=1 held after IDLE.
REQ-038 Two words queued (0x2000, 0x4000) -> exactly two read strobes, 16 consecutive accumulating ticks without a gap, position=1+2=3, underrun=0.
REQ-039 enable dropped at tick 3 of a segment -> IDLE next sysclk, pulse=0, position frozen, no further read.
REQ-040 clr_underrun asserted in the same cycle as an underrun set -> underrun=1; a later clr_underrun alone -> underrun=0.

Source files
------------

// File: rtl/step_profile_pkg.sv
// ---------------------------------------------------------------------------
// step_profile_pkg
// Shared definitions for the step-profile pulse generator: the FSM state
// encoding and the default parameter values used by the top and sub-module.
// ---------------------------------------------------------------------------
package step_profile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH    = 2'd1,
        ST_WAIT_VLD = 2'd2,
        ST_RUN      = 2'd3
    } state_t;

    localparam int DEF_ACC_W     = 16;
    localparam int DEF_DIN_W     = 32;
    localparam int DEF_TICK_DIV  = 25;
    localparam int DEF_SEG_TICKS = 250;
    localparam int DEF_POS_W     = 32;

endpackage

// File: rtl/tick_divider.sv
// ---------------------------------------------------------------------------
// tick_divider
// Free-running divider producing a one-sysclk tick strobe every TICK_DIV
// cycles. It never stops, so tick phase is independent of the FSM.
//
// Ports
//   sysclk  in   system clock
//   reset   in   asynchronous active-high reset
//   tick    out  high for one cycle when the count is TICK_DIV-1
// ---------------------------------------------------------------------------
module tick_divider
    import step_profile_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic sysclk,
    input  logic reset,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Decoded from the count register, so it is 0 while in reset.
    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/step_profile_pulse_gen.sv
// ---------------------------------------------------------------------------
// step_profile_pulse_gen
// Plays a FIFO of profile words as a step/direction pulse train. Each word
// sets a phase-accumulator increment and a direction for SEG_TICKS ticks;
// the accumulator MSB is the step output and its rising edges move position.
//
// Ports
//   sysclk        in   system clock
//   reset         in   asynchronous active-high reset
//   enable        in   run request; low forces IDLE
//   din           in   profile word: [DIN_W-1]=dir, [ACC_W-1:0]=freq
//   empty         in   FIFO empty
//   vld           in   FIFO read data valid
//   clr_underrun  in   clears the sticky underrun flag
//   read          out  FIFO read strobe (one cycle, never while empty)
//   pulse         out  step output (registered accumulator MSB)
//   dir           out  direction of the active word
//   tick          out  divider strobe
//   position      out  signed step count
//   busy          out  state is not IDLE
//   underrun      out  FIFO was empty at a segment boundary
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | stopped; acc/freq/pulse held at 0
// FETCH    | read strobe issued (held off while empty); old freq still runs
// WAIT_VLD | waiting for read data; old freq still runs
// RUN      | applying the current word for SEG_TICKS ticks
// ---------------------------------------------------------------------------
module step_profile_pulse_gen
    import step_profile_pkg::*;
#(
    parameter int ACC_W     = DEF_ACC_W,
    parameter int DIN_W     = DEF_DIN_W,
    parameter int TICK_DIV  = DEF_TICK_DIV,
    parameter int SEG_TICKS = DEF_SEG_TICKS,
    parameter int POS_W     = DEF_POS_W
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIN_W-1:0] din,
    input  logic             empty,
    input  logic             vld,
    input  logic             clr_underrun,
    output logic             read,
    output logic             pulse,
    output logic             dir,
    output logic             tick,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             underrun
);

    localparam int SEG_W = (SEG_TICKS > 2) ? $clog2(SEG_TICKS) : 1;

    state_t           r_state;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_freq;
    logic [SEG_W-1:0] r_seg_cnt;
    logic [POS_W-1:0] r_pos;
    logic             r_pulse;
    logic             r_dir;
    logic             r_underrun;

    logic             w_tick;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_rise;
    logic             w_accum;
    logic [POS_W-1:0] w_pos_step;
    logic             w_unused_din;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .sysclk (sysclk),
        .reset  (reset),
        .tick   (w_tick)
    );

    assign w_acc_next   = r_acc + r_freq;
    assign w_rise       = ~r_acc[ACC_W-1] & w_acc_next[ACC_W-1];
    assign w_accum      = w_tick & (r_state != ST_IDLE) & enable;
    assign w_pos_step   = r_dir ? {POS_W{1'b1}} : {{(POS_W-1){1'b0}}, 1'b1};
    assign w_unused_din = ^din;

    // Read is decoded combinationally against the live empty flag so it can
    // never be issued while the FIFO is empty; FETCH simply waits instead.
    assign read     = (r_state == ST_FETCH) & enable & ~empty;
    assign busy     = (r_state != ST_IDLE);
    assign tick     = w_tick;
    assign pulse    = r_pulse;
    assign dir      = r_dir;
    assign position = r_pos;
    assign underrun = r_underrun;

    // Later assignments in this block override earlier ones: the IDLE clears
    // win over the accumulator update, and the underrun set wins over clear.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_freq     <= '0;
            r_seg_cnt  <= '0;
            r_pos      <= '0;
            r_pulse    <= 1'b0;
            r_dir      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            if (w_accum) begin
                r_acc   <= w_acc_next;
                r_pulse <= w_acc_next[ACC_W-1];
                if (w_rise) begin
                    r_pos <= r_pos + w_pos_step;
                end
            end

            if (clr_underrun) begin
                r_underrun <= 1'b0;
            end

            if (!enable) begin
                r_state <= ST_IDLE;
                r_acc   <= '0;
                r_freq  <= '0;
                r_pulse <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_acc   <= '0;
                        r_freq  <= '0;
                        r_pulse <= 1'b0;
                        if (!empty) begin
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_FETCH: begin
                        if (!empty) begin
                            r_state <= ST_WAIT_VLD;
                        end
                    end
                    ST_WAIT_VLD: begin
                        if (vld) begin
                            r_freq    <= din[ACC_W-1:0];
                            r_dir     <= din[DIN_W-1];
                            r_seg_cnt <= SEG_W'(SEG_TICKS - 1);
                            r_state   <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (w_tick) begin
                            if (r_seg_cnt == '0) begin
                                if (empty) begin
                                    r_underrun <= 1'b1;
                                    r_state    <= ST_IDLE;
                                    r_acc      <= '0;
                                    r_freq     <= '0;
                                    r_pulse    <= 1'b0;
                                end else begin
                                    r_state <= ST_FETCH;
                                end
                            end else begin
                                r_seg_cnt <= r_seg_cnt - 1'b1;
                            end
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
